// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg
// Opcode constants and execute-stage FSM state encoding shared by the ALU
// and the execute stage that wraps it.
// Revision: 1.0
// ============================================================================
package alu_pkg;

  // ALU opcodes
  localparam logic [2:0] SEL_ADD = 3'b000;
  localparam logic [2:0] SEL_SUB = 3'b001;
  localparam logic [2:0] SEL_NOT = 3'b010;
  localparam logic [2:0] SEL_AND = 3'b011;
  localparam logic [2:0] SEL_OR  = 3'b100;
  localparam logic [2:0] SEL_XOR = 3'b101;
  localparam logic [2:0] SEL_LT  = 3'b110;
  localparam logic [2:0] SEL_EQ  = 3'b111;

  // Execute-stage FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Compare opcodes produce a flag, not a value worth accumulating
  function automatic logic writes_acc(input logic [2:0] sel);
    return (sel != SEL_LT) && (sel != SEL_EQ);
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// alu
// 4-bit combinational ALU. Carry, zero and overflow flags are produced only
// for add and subtract; every other opcode reports all flags as 0.
// Revision: 1.0
// ============================================================================
module alu
  import alu_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [2:0] sel_i,
  output logic [3:0] result_o,
  output logic       c_o,
  output logic       z_o,
  output logic       ovf_o
);

  logic [4:0] add_sum;
  logic [4:0] sub_sum;

  // Subtract is a + ~b + 1 so the carry out is the "no borrow" flag
  assign add_sum = {1'b0, a_i} + {1'b0, b_i};
  assign sub_sum = {1'b0, a_i} + {1'b0, ~b_i} + 5'd1;

  // Opcode decode; default arm keeps outputs defined for any select value
  always_comb begin
    result_o = 4'h0;
    c_o      = 1'b0;
    z_o      = 1'b0;
    ovf_o    = 1'b0;
    case (sel_i)
      SEL_ADD: begin
        result_o = add_sum[3:0];
        c_o      = add_sum[4];
        z_o      = (add_sum[3:0] == 4'h0);
        ovf_o    = (a_i[3] == b_i[3]) && (add_sum[3] != a_i[3]);
      end
      SEL_SUB: begin
        result_o = sub_sum[3:0];
        c_o      = sub_sum[4];
        z_o      = (sub_sum[3:0] == 4'h0);
        ovf_o    = (a_i[3] != b_i[3]) && (sub_sum[3] != a_i[3]);
      end
      SEL_NOT: result_o = ~a_i;
      SEL_AND: result_o = a_i & b_i;
      SEL_OR:  result_o = a_i | b_i;
      SEL_XOR: result_o = a_i ^ b_i;
      SEL_LT:  result_o = {3'b000, ($signed(a_i) < $signed(b_i))};
      SEL_EQ:  result_o = {3'b000, (a_i == b_i)};
      default: result_o = 4'h0;
    endcase
  end

endmodule : alu
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// alu_exec_stage
// Single-slot execute stage around the ALU: accept a request, evaluate it the
// following cycle (optionally using the accumulator as operand A), then hold
// the registered response until consumed. A new request can be accepted in
// the same cycle the response is consumed, giving one op per two cycles.
// Revision: 1.0
// ============================================================================
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter logic [3:0] ACC_RESET = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic [2:0] in_sel,
  input  logic       in_use_acc,
  output logic       in_ready,
  output logic       out_valid,
  output logic [3:0] out_result,
  output logic       out_c,
  output logic       out_z,
  output logic       out_ovf,
  input  logic       out_ready,
  output logic [3:0] acc,
  output logic [7:0] op_cnt
);

  logic [1:0] state_q, state_d;
  logic [3:0] a_q, b_q;
  logic [2:0] sel_q;
  logic       use_acc_q;
  logic [3:0] acc_q;
  logic [7:0] op_cnt_q;
  logic [3:0] result_q;
  logic       c_q, z_q, ovf_q;

  logic       accept;
  logic       consume;
  logic       exec;
  logic [3:0] alu_a;
  logic [3:0] alu_result;
  logic       alu_c, alu_z, alu_ovf;

  // Handshake decode; HOLD can take a new request only while draining
  assign out_valid = (state_q == ST_HOLD);
  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;
  assign exec      = (state_q == ST_EXEC);

  // acc was already updated by the previous response, so no stale operand
  assign alu_a = use_acc_q ? acc_q : a_q;

  alu u_alu (
    .a_i      (alu_a),
    .b_i      (b_q),
    .sel_i    (sel_q),
    .result_o (alu_result),
    .c_o      (alu_c),
    .z_o      (alu_z),
    .ovf_o    (alu_ovf)
  );

  // Next-state logic; the unused encoding falls back to IDLE
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = accept ? ST_EXEC : ST_IDLE;
      ST_EXEC: state_d = ST_HOLD;
      ST_HOLD: begin
        if (!out_ready)  state_d = ST_HOLD;
        else if (accept) state_d = ST_EXEC;
        else             state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Operand capture on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= 4'h0;
      b_q       <= 4'h0;
      sel_q     <= 3'b000;
      use_acc_q <= 1'b0;
    end else if (accept) begin
      a_q       <= in_a;
      b_q       <= in_b;
      sel_q     <= in_sel;
      use_acc_q <= in_use_acc;
    end
  end

  // Response registers loaded on the EXEC -> HOLD edge, stable while held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= 4'h0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (exec) begin
      result_q <= alu_result;
      c_q      <= alu_c;
      z_q      <= alu_z;
      ovf_q    <= alu_ovf;
    end
  end

  // Accumulator follows every non-compare result
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          acc_q <= ACC_RESET;
    else if (exec && writes_acc(sel_q)) acc_q <= alu_result;
  end

  // Consumed-response counter, wraps naturally at 8 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          op_cnt_q <= 8'h00;
    else if (consume) op_cnt_q <= op_cnt_q + 8'h01;
  end

  assign out_result = result_q;
  assign out_c      = c_q;
  assign out_z      = z_q;
  assign out_ovf    = ovf_q;
  assign acc        = acc_q;
  assign op_cnt     = op_cnt_q;

endmodule : alu_exec_stage
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
// tb_alu_exec_stage
// Scoreboard bench: accepted requests push an expected response computed by
// an arithmetic reference model; a monitor pops and compares on each consume.
// Revision: 1.0
// ============================================================================
module tb_alu_exec_stage;

  localparam logic [3:0] ACC_RST = 4'h0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_a = 4'h0;
  logic [3:0] in_b = 4'h0;
  logic [2:0] in_sel = 3'b000;
  logic       in_use_acc = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_result;
  logic       out_c, out_z, out_ovf;
  logic       out_ready = 1'b0;
  logic [3:0] acc;
  logic [7:0] op_cnt;

  alu_exec_stage #(.ACC_RESET(ACC_RST)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sel     (in_sel),
    .in_use_acc (in_use_acc),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_c      (out_c),
    .out_z      (out_z),
    .out_ovf    (out_ovf),
    .out_ready  (out_ready),
    .acc        (acc),
    .op_cnt     (op_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r;
    int c;
    int z;
    int ovf;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   consume_cyc[$];
  int   model_acc = 0;
  int   cnt_model = 0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   rand_mode = 1'b0;
  bit   ready_fixed = 1'b1;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sgn4(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  // Reference model written from the opcode definitions with integer math
  function automatic exp_t model(input int a, input int b, input int sel,
                                 input int use_acc, input int accv);
    exp_t e;
    int   opa, s, sd;
    opa = use_acc ? accv : a;
    e.r = 0; e.c = 0; e.z = 0; e.ovf = 0;
    case (sel)
      0: begin
        s = opa + b;
        e.r = s % 16; e.c = (s >= 16);
        sd = sgn4(opa) + sgn4(b);
        e.ovf = (sd > 7) || (sd < -8);
        e.z = (e.r == 0);
      end
      1: begin
        s = opa + (16 - b);
        e.r = s % 16; e.c = (s >= 16);
        sd = sgn4(opa) - sgn4(b);
        e.ovf = (sd > 7) || (sd < -8);
        e.z = (e.r == 0);
      end
      2: e.r = 15 - opa;
      3: e.r = opa & b;
      4: e.r = opa | b;
      5: e.r = opa ^ b;
      6: e.r = (sgn4(opa) < sgn4(b)) ? 1 : 0;
      default: e.r = (opa == b) ? 1 : 0;
    endcase
    e.acc = (sel <= 5) ? e.r : accv;
    return e;
  endfunction

  // Acceptance observer: predicts the response of every accepted request
  always @(negedge clk) begin
    exp_t e;
    if (!rst && in_valid && in_ready) begin
      e = model(int'(in_a), int'(in_b), int'(in_sel), int'(in_use_acc), model_acc);
      model_acc = e.acc;
      sb.push_back(e);
    end
  end

  // Monitor: compares every consumed response against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_response", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("result", int'(out_result), e.r);
        chk("c", int'(out_c), e.c);
        chk("z", int'(out_z), e.z);
        chk("ovf", int'(out_ovf), e.ovf);
        chk("acc", int'(acc), e.acc);
        chk("op_cnt", int'(op_cnt), cnt_model);
        cnt_model = (cnt_model + 1) % 256;
        consume_cyc.push_back(cyc);
      end
    end
  end

  // Consumer side: random or fixed backpressure
  always @(posedge clk) begin
    #1;
    out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    model_acc = int'(ACC_RST);
    cnt_model = 0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_acc", int'(acc), int'(ACC_RST));
    chk("rst_op_cnt", int'(op_cnt), 0);
    chk("rst_result", int'(out_result), 0);
    @(posedge clk); #1;
  endtask

  // Drive a request and hold it until accepted; returns at posedge+1
  task automatic send(input int a, input int b, input int sel, input int ua);
    int n;
    in_valid = 1'b1; in_a = 4'(a); in_b = 4'(b); in_sel = 3'(sel); in_use_acc = 1'(ua);
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        break;
      end
      n++;
      if (n > 200) begin
        chk("accept_timeout", 1, 0);
        in_valid = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int snap;
    rand_mode = 1'b0;
    ready_fixed = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Add overflow: 7 + 1
    send(4'b0111, 4'b0001, 0, 0);
    drain();
    chk("add_ovf_acc", int'(acc), 8);

    // Subtract to zero: 3 - 3
    send(4'b0011, 4'b0011, 1, 0);
    drain();
    chk("sub_zero_acc", int'(acc), 0);

    // Back-to-back accumulate: 3, 6, 9 two cycles apart
    do_reset();
    consume_cyc.delete();
    send(0, 3, 0, 1);
    send(0, 3, 0, 1);
    send(0, 3, 0, 1);
    drain();
    @(negedge clk);
    chk("b2b_acc", int'(acc), 9);
    chk("b2b_op_cnt", int'(op_cnt), 3);
    chk("b2b_n_resp", consume_cyc.size(), 3);
    if (consume_cyc.size() == 3) begin
      chk("b2b_gap1", consume_cyc[1] - consume_cyc[0], 2);
      chk("b2b_gap2", consume_cyc[2] - consume_cyc[1], 2);
    end
    @(posedge clk); #1;

    // Compare leaves accumulator untouched: acc=5 then 2 < 4
    send(5, 0, 4, 0);
    drain();
    send(2, 4, 6, 0);
    drain();
    chk("lt_acc_kept", int'(acc), 5);

    // Backpressure: hold response for 5 cycles
    ready_fixed = 1'b0;
    @(posedge clk); #1;
    snap = cnt_model;
    send(3, 4, 0, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_op_cnt", int'(op_cnt), snap);
      if (sb.size() > 0) chk("bp_result", int'(out_result), sb[0].r);
      else               chk("bp_pending", 0, 1);
    end
    ready_fixed = 1'b1;
    drain();
    @(negedge clk);
    chk("bp_release_cnt", int'(op_cnt), (snap + 1) % 256);
    chk("bp_released", int'(out_valid), 0);
    @(posedge clk); #1;

    // Reset while in EXEC: operation abandoned
    send(1, 1, 0, 0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_acc", int'(acc), int'(ACC_RST));
    sb.delete();
    model_acc = int'(ACC_RST);
    cnt_model = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_resp", int'(out_valid), 0);
    end
    @(posedge clk); #1;

    // Randomized traffic with random backpressure
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        repeat (int'($urandom_range(1, 3))) @(posedge clk);
        #1;
      end
    end
    drain();
    rand_mode = 1'b0;
    ready_fixed = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_alu_exec_stage
`default_nettype wire
